// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: bundles the cpu-side and memory-side signals of mem_sequencer.
// Rev 1.0 -- master modport is the sequencer, slave modport is the cpu/memory environment.
`default_nettype none

interface mem_sequencer_if;
   logic [31:0] PC;
   logic [31:0] ALU_result;
   logic [31:0] write_data;
   logic        mem_write;
   logic [31:0] instruction;
   logic [31:0] read_data;
   logic        cpu_enable;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] retired;
   logic        fault;

   modport master (
      input  PC, ALU_result, write_data, mem_write, mem_ready, mem_rdata,
      output instruction, read_data, cpu_enable, mem_req, mem_addr, mem_we,
             mem_wdata, retired, fault
   );

   modport slave (
      output PC, ALU_result, write_data, mem_write, mem_ready, mem_rdata,
      input  instruction, read_data, cpu_enable, mem_req, mem_addr, mem_we,
             mem_wdata, retired, fault
   );
endinterface

`default_nettype wire

// File: rtl/mem_sequencer.sv
// mem_sequencer: shares one memory between fetch and load/store, commits via cpu_enable. Rev 1.0
// Optional bus timeout with sticky fault: define MEM_SEQUENCER_TIMEOUT_EN.
`default_nettype none

module mem_sequencer #(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  wire logic        clock,
   input  wire logic        reset,
   mem_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DATA   = 3'd2,
      COMMIT = 3'd3,
      FAULT  = 3'd4
   } state_t;

   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   state_t      state;
   state_t      state_next;
   logic        req;
   logic        we;
   logic        cpu_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        is_mem_op;
   logic        timeout;
   logic [31:0] instruction_q;
   logic [31:0] read_data_q;
   logic [31:0] retired_q;

   assign is_mem_op = (bus.mem_rdata[6:0] == OP_LOAD) || (bus.mem_rdata[6:0] == OP_STORE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request outputs decode from the registered state only, so reset drops them at once.
   always_comb begin
      state_next = state;
      req        = 1'b0;
      we         = 1'b0;
      cpu_en     = 1'b0;
      addr       = 32'h0;
      wdata      = 32'h0;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            req  = 1'b1;
            addr = bus.PC;
            if (bus.mem_ready) begin
               state_next = is_mem_op ? DATA : COMMIT;
            end else if (timeout) begin
               state_next = FAULT;
            end
         end
         DATA: begin
            req   = 1'b1;
            addr  = bus.ALU_result;
            we    = bus.mem_write;
            wdata = bus.write_data;
            if (bus.mem_ready) begin
               state_next = COMMIT;
            end else if (timeout) begin
               state_next = FAULT;
            end
         end
         COMMIT: begin
            cpu_en     = 1'b1;
            state_next = FETCH;
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instruction_q <= NOP;
         read_data_q   <= 32'h0;
         retired_q     <= 32'h0;
      end else begin
         if (state == FETCH && bus.mem_ready) begin
            instruction_q <= bus.mem_rdata;
         end
         if (state == DATA && bus.mem_ready && !we) begin
            read_data_q <= bus.mem_rdata;
         end
         if (state == COMMIT) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

`ifdef MEM_SEQUENCER_TIMEOUT_EN
   localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

   logic [15:0] wait_cnt;

   // Clearing whenever no access is pending covers entry into both FETCH and DATA.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wait_cnt <= 16'h0;
      end else if (!req || bus.mem_ready) begin
         wait_cnt <= 16'h0;
      end else begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   assign timeout   = !bus.mem_ready && ((wait_cnt + 16'd1) == LIMIT);
   assign bus.fault = (state == FAULT);
`else
   logic unused_wait_limit;

   assign unused_wait_limit = |WAIT_LIMIT;
   assign timeout           = 1'b0;
   assign bus.fault         = 1'b0;
`endif

   assign bus.mem_req     = req;
   assign bus.mem_we      = we;
   assign bus.mem_addr    = addr;
   assign bus.mem_wdata   = wdata;
   assign bus.cpu_enable  = cpu_en;
   assign bus.instruction = instruction_q;
   assign bus.read_data   = read_data_q;
   assign bus.retired     = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized cpu/memory environment with a per-instruction timing model.
// Rev 1.0
`default_nettype none

module tb_mem_sequencer;

   localparam int          WL       = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;

   logic clock = 1'b0;
   logic reset = 1'b0;

   mem_sequencer_if bus ();

   mem_sequencer #(.WAIT_LIMIT(WL)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_insn;
   logic [31:0] exp_rd;
   logic [31:0] exp_ret;
   logic [6:0]  alu_ops [5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic idle_cycle();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = $urandom;
      bus.mem_write = 1'b1;
      @(negedge clock);
      chk("idle_req", 32'(bus.mem_req), 32'h0);
      chk("idle_we", 32'(bus.mem_we), 32'h0);
      chk("idle_en", 32'(bus.cpu_enable), 32'h0);
      chk("idle_insn", bus.instruction, exp_insn);
      chk("idle_retired", bus.retired, exp_ret);
      @(posedge clock); #1;
   endtask

   // One instruction: fetch with wf wait cycles, optional data phase with wd waits, commit.
   // abort_d >= 0 pulses reset during that data-phase cycle and ends the instruction.
   task automatic run_instr(input logic [31:0] insn, input logic [31:0] pc,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] ldata, input int wf, input int wd,
                            input int abort_d);
      logic is_ld;
      logic is_st;
      is_ld = (insn[6:0] == OP_LOAD);
      is_st = (insn[6:0] == OP_STORE);
      bus.PC         = pc;
      bus.ALU_result = addr;
      bus.write_data = wdata;
      for (int i = 0; i <= wf; i++) begin
         bus.mem_write = 1'($urandom);
         bus.mem_ready = (i == wf);
         bus.mem_rdata = (i == wf) ? insn : $urandom;
         @(negedge clock);
         chk("fetch_req", 32'(bus.mem_req), 32'h1);
         chk("fetch_addr", bus.mem_addr, pc);
         chk("fetch_we", 32'(bus.mem_we), 32'h0);
         chk("fetch_wdata", bus.mem_wdata, 32'h0);
         chk("fetch_en", 32'(bus.cpu_enable), 32'h0);
         chk("fetch_insn", bus.instruction, exp_insn);
         chk("fetch_rd", bus.read_data, exp_rd);
         chk("fetch_retired", bus.retired, exp_ret);
         @(posedge clock); #1;
      end
      exp_insn = insn;
      if (is_ld || is_st) begin
         for (int i = 0; i <= wd; i++) begin
            bus.mem_write = is_st;
            bus.mem_ready = (i == wd);
            bus.mem_rdata = (i == wd && is_ld) ? ldata : $urandom;
            @(negedge clock);
            chk("data_req", 32'(bus.mem_req), 32'h1);
            chk("data_addr", bus.mem_addr, addr);
            chk("data_we", 32'(bus.mem_we), 32'(is_st));
            chk("data_wdata", bus.mem_wdata, wdata);
            chk("data_en", 32'(bus.cpu_enable), 32'h0);
            chk("data_insn", bus.instruction, exp_insn);
            chk("data_rd", bus.read_data, exp_rd);
            if (i == abort_d) begin
               #1 reset = 1'b0;
               #1;
               exp_insn = NOP;
               exp_rd   = 32'h0;
               exp_ret  = 32'h0;
               chk("abort_req", 32'(bus.mem_req), 32'h0);
               chk("abort_we", 32'(bus.mem_we), 32'h0);
               chk("abort_retired", bus.retired, exp_ret);
               chk("abort_insn", bus.instruction, exp_insn);
               chk("abort_rd", bus.read_data, exp_rd);
               @(posedge clock); #1;
               reset = 1'b1;
               idle_cycle();
               return;
            end
            @(posedge clock); #1;
         end
         if (is_ld) exp_rd = ldata;
      end
      bus.mem_write = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = $urandom;
      @(negedge clock);
      chk("commit_en", 32'(bus.cpu_enable), 32'h1);
      chk("commit_req", 32'(bus.mem_req), 32'h0);
      chk("commit_we", 32'(bus.mem_we), 32'h0);
      chk("commit_wdata", bus.mem_wdata, 32'h0);
      chk("commit_insn", bus.instruction, exp_insn);
      chk("commit_rd", bus.read_data, exp_rd);
      chk("commit_retired", bus.retired, exp_ret);
      @(posedge clock); #1;
      exp_ret = exp_ret + 32'd1;
   endtask

   function automatic logic [31:0] rand_insn(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         1:       return {r[31:7], OP_LOAD};
         2:       return {r[31:7], OP_STORE};
         default: return {r[31:7], alu_ops[$urandom_range(0, 4)]};
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      alu_ops[0] = 7'b0010011;
      alu_ops[1] = 7'b0110011;
      alu_ops[2] = 7'b0110111;
      alu_ops[3] = 7'b1101111;
      alu_ops[4] = 7'b1100011;
      bus.PC         = 32'h0;
      bus.ALU_result = 32'h0;
      bus.write_data = 32'hA5A5_A5A5;
      bus.mem_write  = 1'b1;
      bus.mem_ready  = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      exp_insn = NOP;
      exp_rd   = 32'h0;
      exp_ret  = 32'h0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_insn", bus.instruction, NOP);
      chk("rst_rd", bus.read_data, 32'h0);
      chk("rst_retired", bus.retired, 32'h0);
      chk("rst_fault", 32'(bus.fault), 32'h0);
      chk("rst_en", 32'(bus.cpu_enable), 32'h0);
      chk("rst_req", 32'(bus.mem_req), 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'h0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
      reset = 1'b1;
      idle_cycle();

      run_instr(32'h0050_0093, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 0, 0, -1);
      chk("retired_after_addi", bus.retired, 32'h1);
      run_instr(32'h0000_A103, 32'h0000_0004, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 3, -1);
      run_instr(32'h0020_A023, 32'h0000_0008, 32'h44, 32'h1234_5678, 32'h0, 1, 0, -1);
      chk("rd_kept_after_sw", bus.read_data, 32'hDEAD_BEEF);

      for (int n = 0; n < 40; n++) begin
         int k;
         k = $urandom_range(0, 2);
         run_instr(rand_insn(k), $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, WL - 1), $urandom_range(0, WL - 1), -1);
      end
      chk("retired_after_random", bus.retired, 32'd43);

      run_instr(32'h0000_A103, 32'h0000_0100, 32'h80, 32'h0, 32'hCAFE_F00D, 1, 5, 2);
      for (int n = 0; n < 3; n++) begin
         run_instr(rand_insn($urandom_range(0, 2)), $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end
      chk("retired_after_restart", bus.retired, 32'd3);

      bus.PC        = 32'h0000_0200;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
`ifdef MEM_SEQUENCER_TIMEOUT_EN
         chk("to_fault", 32'(bus.fault), 32'(i >= WL));
         chk("to_req", 32'(bus.mem_req), 32'(i < WL));
`else
         chk("to_fault", 32'(bus.fault), 32'h0);
         chk("to_req", 32'(bus.mem_req), 32'h1);
         chk("to_addr", bus.mem_addr, bus.PC);
`endif
         chk("to_en", 32'(bus.cpu_enable), 32'h0);
         @(posedge clock); #1;
      end
      reset = 1'b0;
      #1;
      chk("final_rst_fault", 32'(bus.fault), 32'h0);
      chk("final_rst_req", 32'(bus.mem_req), 32'h0);
      @(posedge clock); #1;
      reset = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
